// File: rtl/alu.sv
// Registered single-cycle ALU: eight operations selected by sel, with result
// and carry/zero/negative/overflow flags captured on every rising clock edge.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    // Signed overflow from operand and result sign bits only.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    always_comb begin
        // Extra top bit of the zero-extended difference is the unsigned borrow.
        sum_w      = {1'b0, a} + {1'b0, b};
        diff_w     = {1'b0, a} - {1'b0, b};
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (sel)
            OP_ADD: begin
                result_d   = sum_w[WIDTH-1:0];
                carry_d    = sum_w[WIDTH];
                overflow_d = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_w[WIDTH-1]);
            end
            OP_SUB: begin
                result_d   = diff_w[WIDTH-1:0];
                carry_d    = diff_w[WIDTH];
                overflow_d = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_w[WIDTH-1]);
            end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_NOT: result_d = ~a;
            OP_SHL: begin
                result_d = {a[WIDTH-2:0], 1'b0};
                carry_d  = a[WIDTH-1];
            end
            OP_SHR: begin
                result_d = {1'b0, a[WIDTH-1:1]};
                carry_d  = a[0];
            end
            default: begin
                result_d   = 'x;
                carry_d    = 1'bx;
                overflow_d = 1'bx;
            end
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the 4-bit registered ALU; observed vector is
// {result, carry, zero, negative, overflow}.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks;
    int failures;

    alu #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {result, carry, zero, negative, overflow};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed r/c/z/n/v=%b required=%b", tag, got, exp);
        end
    endtask

    // Drive inputs, capture on the next rising edge, sample 1 ns later.
    task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic [2:0] si,
                        input logic [7:0] exp, input string tag);
        a   = ai;
        b   = bi;
        sel = si;
        @(posedge clk);
        #1;
        check(tag, obs(), exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a   = 4'($urandom);
        b   = 4'($urandom);
        sel = 3'($urandom);
        #1;
        check("reset_t0", obs(), 8'b0000_0000);
        repeat (3) begin
            @(posedge clk);
            a   = 4'($urandom);
            b   = 4'($urandom);
            sel = 3'($urandom);
        end
        #1;
        check("reset_held", obs(), 8'b0000_0000);
        @(negedge clk);
        rst = 1'b0;

        step(4'b0110, 4'b1001, 3'b000, 8'b1111_0010, "add_0110_1001");
        step(4'b1111, 4'b0001, 3'b000, 8'b0000_1100, "add_wrap");
        step(4'b0111, 4'b0001, 3'b000, 8'b1000_0011, "add_ovf");
        step(4'b1001, 4'b1101, 3'b001, 8'b1100_1010, "sub_borrow");
        step(4'b0111, 4'b1000, 3'b001, 8'b1111_1011, "sub_ovf_pos");
        step(4'b1000, 4'b0001, 3'b001, 8'b0111_0001, "sub_ovf_neg");
        step(4'b0101, 4'b0011, 3'b001, 8'b0010_0000, "sub_plain");
        step(4'b0101, 4'b0010, 3'b010, 8'b0000_0100, "and_zero");
        step(4'b1010, 4'b1010, 3'b011, 8'b1010_0010, "or");
        step(4'b0011, 4'b0110, 3'b100, 8'b0101_0000, "xor");
        step(4'b1001, 4'b0000, 3'b101, 8'b0110_0000, "not");
        step(4'b1001, 4'b1111, 3'b101, 8'b0110_0000, "not_ignores_b");
        step(4'b1001, 4'b0000, 3'b110, 8'b0010_1000, "shl");
        step(4'b1001, 4'b0000, 3'b111, 8'b0100_1000, "shr");
        step(4'b0000, 4'b0000, 3'b111, 8'b0000_0100, "shr_zero");
        step(4'b0100, 4'b0000, 3'b110, 8'b1000_0010, "shl_neg");

        // Outputs hold between edges even when inputs change.
        a   = 4'b0001;
        b   = 4'b0001;
        sel = 3'b000;
        #3;
        check("hold_mid_cycle", obs(), 8'b1000_0010);
        @(posedge clk);
        #1;
        check("hold_next_edge", obs(), 8'b0010_0000);

        // X inputs, then recovery on the next known capture.
        a   = 'x;
        b   = 'x;
        sel = 3'b000;
        @(posedge clk);
        #1;
        step(4'b0011, 4'b0100, 3'b000, 8'b0111_0000, "x_recover");

        // Asynchronous reset between edges clears outputs before the next edge.
        step(4'b1111, 4'b1111, 3'b011, 8'b1111_0010, "pre_async");
        #3;
        rst = 1'b1;
        #1;
        check("async_clear", obs(), 8'b0000_0000);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1110, 4'b0011, 3'b000, 8'b0001_1000, "post_reset_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
